// File: rtl/dll_normalizer_pkg.sv
// dll_normalizer_pkg: constants shared across the DLL discriminator path,
// including dll_priority_enc, plus the stage-1 pipe payload type.
// Build option: DLL_NORM_ROUND_EN adds a guard bit to the stage-1 payload.
package dll_normalizer_pkg;

  localparam int unsigned DLL_VALUE_WIDTH = 36;
  localparam int unsigned DLL_POS_WIDTH   = 6;
  localparam int unsigned DLL_MANT_WIDTH  = 11;
  localparam int unsigned DLL_POS_MIN     = DLL_MANT_WIDTH - 1;
  localparam int unsigned DLL_POS_MAX     = DLL_VALUE_WIDTH - 1;
  localparam int unsigned DLL_ENC_LATENCY = 2;
  localparam int unsigned DLL_SHIFT_WIDTH = 5;
  // After the coarse (multiple-of-8) shift at most 7 more bits are dropped.
  localparam int unsigned DLL_V1_WIDTH    = DLL_MANT_WIDTH + 7;

  typedef struct packed {
    logic [DLL_V1_WIDTH-1:0]    v1;
    logic [DLL_SHIFT_WIDTH-1:0] sh;
    logic                       err;
`ifdef DLL_NORM_ROUND_EN
    logic                       guard;
`endif
  } dll_s1_t;

endpackage

// File: rtl/dll_normalizer_if.sv
// dll_normalizer_if: sample/result bundle between the encoder side and the
// normalizer.
//   value_valid, value, pos    : producer -> normalizer
//   out_valid, mant, shift,
//   pos_err                    : normalizer -> consumer
// master = producer/consumer side, slave = normalizer.
interface dll_normalizer_if;
  import dll_normalizer_pkg::*;

  logic                       value_valid;
  logic [DLL_VALUE_WIDTH-1:0] value;
  logic [DLL_POS_WIDTH-1:0]   pos;
  logic                       out_valid;
  logic [DLL_MANT_WIDTH-1:0]  mant;
  logic [DLL_SHIFT_WIDTH-1:0] shift;
  logic                       pos_err;

  modport master (
    output value_valid, value, pos,
    input  out_valid, mant, shift, pos_err
  );

  modport slave (
    input  value_valid, value, pos,
    output out_valid, mant, shift, pos_err
  );

endinterface

// File: rtl/dll_normalizer_align_delay.sv
// dll_normalizer_align_delay: DEPTH-stage valid+data delay line that
// realigns the raw value with the encoder's position output.
// Ports: clk, reset (async, active-high), i_valid/i_data in,
//        o_valid/o_data out (DEPTH cycles later, registered).
module dll_normalizer_align_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 36
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][WIDTH-1:0] r_data;

  // Shift register; reset drops every in-flight sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/dll_normalizer.sv
// dll_normalizer: normalizes a 36-bit DLL magnitude to an 11-bit mantissa
// using the MSB position from dll_priority_enc, via a 2-stage barrel shift.
// Ports: clk, reset (async, active-high), bus (dll_normalizer_if.slave).
// Latency: value -> outputs 4 cycles, pos -> outputs 2 cycles.
// Build option: DLL_NORM_ROUND_EN enables round-half-up with saturation;
// without it the mantissa is truncated.
module dll_normalizer
  import dll_normalizer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  dll_normalizer_if.slave  bus
);

  logic                       w_dly_valid;
  logic [DLL_VALUE_WIDTH-1:0] w_dly_value;
  logic                       w_pos_bad;
  logic [DLL_SHIFT_WIDTH-1:0] w_sh;
  dll_s1_t                    w_s1_next;
  logic [DLL_MANT_WIDTH-1:0]  w_mant_trunc;
  logic [DLL_MANT_WIDTH-1:0]  w_mant;

  logic                       r_s1_valid;
  dll_s1_t                    r_s1;
  logic                       r_out_valid;
  logic [DLL_MANT_WIDTH-1:0]  r_mant;
  logic [DLL_SHIFT_WIDTH-1:0] r_shift;
  logic                       r_pos_err;

  dll_normalizer_align_delay #(
    .DEPTH (DLL_ENC_LATENCY),
    .WIDTH (DLL_VALUE_WIDTH)
  ) u_align (
    .clk     (clk),
    .reset   (reset),
    .i_valid (bus.value_valid),
    .i_data  (bus.value),
    .o_valid (w_dly_valid),
    .o_data  (w_dly_value)
  );

  // Stage 1: shift amount, range check and coarse (byte) shift.
  assign w_pos_bad = (bus.pos < DLL_POS_WIDTH'(DLL_POS_MIN)) ||
                     (bus.pos > DLL_POS_WIDTH'(DLL_POS_MAX));
  assign w_sh      = w_pos_bad ? '0
                   : DLL_SHIFT_WIDTH'(bus.pos - DLL_POS_WIDTH'(DLL_POS_MIN));

  always_comb begin
    w_s1_next     = '0;
    w_s1_next.sh  = w_sh;
    w_s1_next.err = w_pos_bad;
    w_s1_next.v1  = DLL_V1_WIDTH'(w_dly_value >> {w_sh[4:3], 3'b000});
`ifdef DLL_NORM_ROUND_EN
    // Guard is the first bit below the mantissa, i.e. value[pos-11].
    if (w_sh != '0) begin
      w_s1_next.guard = w_dly_value[DLL_POS_WIDTH'(w_sh) - DLL_POS_WIDTH'(1)];
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else begin
      r_s1_valid <= w_dly_valid;
      if (w_dly_valid) begin
        r_s1 <= w_s1_next;
      end
    end
  end

  // Stage 2: fine shift (0..7) and optional rounding.
  assign w_mant_trunc = DLL_MANT_WIDTH'(r_s1.v1 >> r_s1.sh[2:0]);

`ifdef DLL_NORM_ROUND_EN
  logic [DLL_MANT_WIDTH:0] w_sum;
  assign w_sum  = {1'b0, w_mant_trunc} + {{DLL_MANT_WIDTH{1'b0}}, r_s1.guard};
  // Carry past the mantissa width saturates rather than wrapping.
  assign w_mant = w_sum[DLL_MANT_WIDTH] ? '1 : w_sum[DLL_MANT_WIDTH-1:0];
`else
  assign w_mant = w_mant_trunc;
`endif

  // Outputs hold while no new sample completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_mant      <= '0;
      r_shift     <= '0;
      r_pos_err   <= 1'b0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_mant    <= r_s1.err ? '0 : w_mant;
        r_shift   <= r_s1.sh;
        r_pos_err <= r_s1.err;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.mant      = r_mant;
  assign bus.shift     = r_shift;
  assign bus.pos_err   = r_pos_err;

endmodule

// File: tb/tb_dll_normalizer.sv
// tb_dll_normalizer: directed vectors with hand-computed results, driven on a
// per-cycle schedule (value at cycle s, pos at s+2, result checked at s+4),
// including a mid-stream reset pulse.
module tb_dll_normalizer;
  import dll_normalizer_pkg::*;

  localparam int NCYC  = 40;
  localparam int NVEC  = 24;

  typedef struct packed {
    logic [35:0] value;
    logic [5:0]  pos;
    logic [10:0] mant;
    logic [4:0]  shift;
    logic        err;
  } vec_t;

  logic clk;
  logic reset;
  dll_normalizer_if bus ();

  dll_normalizer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t tbl [NVEC];
  int   sched [NCYC];
  bit   rst_c [NCYC];
  int   n_vec;
  int   n_miss;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // A sample is lost if reset is high at its capture edge or while in flight.
  function automatic bit killed(input int s);
    for (int r = s; r <= s + 3; r++) begin
      if (r < NCYC && rst_c[r]) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    logic        ev;
    logic [10:0] em;
    logic [4:0]  es;
    logic        ee;
    bit          prev_rst;
    int          idx;

    n_vec  = 0;
    n_miss = 0;

    tbl[0]  = '{36'h8_0000_0000, 6'd35, 11'h400, 5'd25, 1'b0};
    tbl[1]  = '{36'h0_0000_07FF, 6'd10, 11'h7FF, 5'd0,  1'b0};
    tbl[2]  = '{36'h0_0012_3456, 6'd20, 11'h48D, 5'd10, 1'b0};
`ifdef DLL_NORM_ROUND_EN
    tbl[3]  = '{36'h0_0000_0AAB, 6'd11, 11'h556, 5'd1,  1'b0};
`else
    tbl[3]  = '{36'h0_0000_0AAB, 6'd11, 11'h555, 5'd1,  1'b0};
`endif
    tbl[4]  = '{36'h0_0000_0FFF, 6'd11, 11'h7FF, 5'd1,  1'b0};
    tbl[5]  = '{36'h0_0001_2345, 6'd40, 11'h000, 5'd0,  1'b1};
    tbl[6]  = '{36'h0_0001_2345, 6'd5,  11'h000, 5'd0,  1'b1};
    tbl[7]  = '{36'h0_0000_0000, 6'd10, 11'h000, 5'd0,  1'b0};
    tbl[8]  = '{36'hF_FFFF_FFFF, 6'd35, 11'h7FF, 5'd25, 1'b0};
`ifdef DLL_NORM_ROUND_EN
    tbl[9]  = '{36'h0_0000_0C01, 6'd11, 11'h601, 5'd1,  1'b0};
`else
    tbl[9]  = '{36'h0_0000_0C01, 6'd11, 11'h600, 5'd1,  1'b0};
`endif
    tbl[10] = '{36'h0_0001_8000, 6'd16, 11'h600, 5'd6,  1'b0};
    tbl[11] = '{36'h4_0000_0100, 6'd34, 11'h400, 5'd24, 1'b0};
`ifdef DLL_NORM_ROUND_EN
    tbl[12] = '{36'h0_0004_0080, 6'd18, 11'h401, 5'd8,  1'b0};
`else
    tbl[12] = '{36'h0_0004_0080, 6'd18, 11'h400, 5'd8,  1'b0};
`endif
    tbl[13] = '{36'h0_0001_2345, 6'd36, 11'h000, 5'd0,  1'b1};
    tbl[14] = '{36'h0_0000_03FF, 6'd9,  11'h000, 5'd0,  1'b1};
    tbl[15] = tbl[3];
    for (int k = 0; k < 8; k++) begin
      tbl[16+k] = '{36'(36'h400 + 36'(k + 1)), 6'd10, 11'(11'h400 + 11'(k + 1)), 5'd0, 1'b0};
    end

    // Schedule: reset 0..2, samples 0..6 at 3..9, gap 10..11, samples
    // 7..15 at 12..20, stream 16..23 at 24..31 with reset pulse at 29.
    for (int t = 0; t < NCYC; t++) begin
      sched[t] = -1;
      rst_c[t] = 1'b0;
    end
    for (int t = 0; t < 3; t++) rst_c[t] = 1'b1;
    for (int k = 0; k < 7; k++) sched[3+k] = k;
    for (int k = 7; k < 16; k++) sched[5+k] = k;
    for (int k = 16; k < 24; k++) sched[8+k] = k;
    rst_c[29] = 1'b1;

    reset           = 1'b1;
    bus.value_valid = 1'b0;
    bus.value       = '0;
    bus.pos         = '0;
    ev = 1'b0; em = '0; es = '0; ee = 1'b0;

    for (int t = 0; t < NCYC; t++) begin
      @(negedge clk);
      prev_rst = (t == 0) ? 1'b1 : rst_c[t-1];
      if (prev_rst) begin
        ev = 1'b0; em = '0; es = '0; ee = 1'b0;
      end else if (t >= 4 && sched[t-4] >= 0 && !killed(t-4)) begin
        idx = sched[t-4];
        ev = 1'b1;
        em = tbl[idx].mant;
        es = tbl[idx].shift;
        ee = tbl[idx].err;
      end else begin
        ev = 1'b0;
      end
      check($sformatf("c%0d out_valid", t), 64'(bus.out_valid), 64'(ev));
      check($sformatf("c%0d mant", t),      64'(bus.mant),      64'(em));
      check($sformatf("c%0d shift", t),     64'(bus.shift),     64'(es));
      check($sformatf("c%0d pos_err", t),   64'(bus.pos_err),   64'(ee));

      reset = rst_c[t];
      if (sched[t] >= 0) begin
        bus.value_valid = 1'b1;
        bus.value       = tbl[sched[t]].value;
      end else begin
        bus.value_valid = 1'b0;
        bus.value       = 36'hF_0F0F_0F0F;
      end
      if (t >= 2 && sched[t-2] >= 0) bus.pos = tbl[sched[t-2]].pos;
      else                           bus.pos = 6'd63;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
